// File: rtl/audio_i2s_tx.sv
// I2S serializer for the sample-ROM audio path: fetches one mono sample per frame and sends it on both channels.
// Optional build macro AUDIO_TX_ATTEN_EN adds an Atten input that arithmetically right-shifts each fetched sample.
//   state | meaning
//   IDLE  | outputs parked, waiting for INIT
//   FILL  | first sample fetch in flight
//   RUN   | BCLK running, frames streaming
module audio_i2s_tx #(
  parameter int DATA_W   = 16,
  parameter int SLOT_W   = 32,
  parameter int BCLK_DIV = 4,
  parameter int ROM_LAT  = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              INIT,
  input  logic [DATA_W-1:0] Sample,
`ifdef AUDIO_TX_ATTEN_EN
  input  logic [2:0]        Atten,
`endif
  output logic              sample_req,
  output logic              data_over,
  output logic              BCLK,
  output logic              LRCLK,
  output logic              DACDAT
);

  localparam int BC_W  = $clog2(2 * SLOT_W);
  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int LAT_W = $clog2(ROM_LAT + 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;
  logic [BC_W-1:0]   bit_cnt;
  logic [LAT_W-1:0]  lat_cnt;
  logic              lat_pend;
  logic              stop;
  logic [DATA_W-1:0] buffer;
  logic [DATA_W-1:0] frame;
  logic [DATA_W-1:0] latch_val;
  logic [BC_W-1:0]   bit_nxt;
  logic              dac_nxt;
  logic              latch_now;
  int                k;

  always_comb begin
`ifdef AUDIO_TX_ATTEN_EN
    latch_val = $signed(Sample) >>> Atten;
`else
    latch_val = Sample;
`endif
  end

  // Next bit position and the data bit it carries; the slot's first bit is the I2S delay bit.
  always_comb begin
    bit_nxt = (bit_cnt == BC_W'(2 * SLOT_W - 1)) ? '0 : bit_cnt + 1'b1;
    k = int'(bit_nxt);
    if (k >= SLOT_W) k = k - SLOT_W;
    dac_nxt = 1'b0;
    if (k >= 1 && k <= DATA_W) dac_nxt = frame[DATA_W - k];
  end

  assign latch_now = lat_pend && (lat_cnt == '0);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      lat_cnt    <= '0;
      lat_pend   <= 1'b0;
      stop       <= 1'b0;
      buffer     <= '0;
      frame      <= '0;
      sample_req <= 1'b0;
      data_over  <= 1'b0;
      BCLK       <= 1'b0;
      LRCLK      <= 1'b1;
      DACDAT     <= 1'b0;
    end else begin
      sample_req <= 1'b0;
      data_over  <= 1'b0;
      if (lat_pend) begin
        if (latch_now) begin
          buffer   <= latch_val;
          lat_pend <= 1'b0;
        end else begin
          lat_cnt <= lat_cnt - 1'b1;
        end
      end
      case (state)
        IDLE: begin
          BCLK    <= 1'b0;
          LRCLK   <= 1'b1;
          DACDAT  <= 1'b0;
          stop    <= 1'b0;
          div_cnt <= '0;
          bit_cnt <= '0;
          if (INIT) begin
            state      <= FILL;
            sample_req <= 1'b1;
            lat_pend   <= 1'b1;
            lat_cnt    <= LAT_W'(ROM_LAT);
          end
        end
        FILL: begin
          stop <= ~INIT;
          if (latch_now) begin
            stop <= 1'b0;
            if (stop || !INIT) begin
              state <= IDLE;
            end else begin
              state   <= RUN;
              div_cnt <= '0;
              bit_cnt <= BC_W'(2 * SLOT_W - 1);
              BCLK    <= 1'b0;
            end
          end
        end
        RUN: begin
          stop <= ~INIT;
          if (div_cnt == DIV_W'(BCLK_DIV - 1)) begin
            div_cnt <= '0;
            BCLK    <= ~BCLK;
            if (BCLK) begin
              bit_cnt <= bit_nxt;
              DACDAT  <= dac_nxt;
              if (bit_nxt == '0) begin
                // A pending stop replaces the frame boundary with a clean park in IDLE.
                if (stop) begin
                  state  <= IDLE;
                  LRCLK  <= 1'b1;
                  DACDAT <= 1'b0;
                  stop   <= 1'b0;
                end else begin
                  LRCLK      <= 1'b0;
                  frame      <= buffer;
                  sample_req <= 1'b1;
                  data_over  <= 1'b1;
                  lat_pend   <= 1'b1;
                  lat_cnt    <= LAT_W'(ROM_LAT);
                end
              end else if (bit_nxt == BC_W'(SLOT_W)) begin
                LRCLK <= 1'b1;
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/audio_i2s_tx.md
Name: audio_i2s_tx

Overview:
- Serializing end of the sample-ROM audio path.
- The address generator walks ROM addresses and advances on data_over. This block fetches the 16-bit mono sample at the current address and shifts it out as a standard I2S stream (BCLK/LRCLK/DACDAT) to the board DAC.
- Pulses data_over once per stereo frame so the generator steps to the next address.

Parameters:
- DATA_W, 16, sample width in bits.
- SLOT_W, 32, BCLK periods per channel slot; must be >= DATA_W+1.
- BCLK_DIV, 4, Clk cycles per BCLK half-period; must be >= 1.
- ROM_LAT, 2, Clk cycles from sample_req to valid Sample; must be in 1..(2*BCLK_DIV*2*SLOT_W - 1).

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- INIT  in  1  run enable from the address generator; level.
- Sample  in  DATA_W  ROM read data for the current address; two's complement.
- sample_req  out  1  one-cycle fetch strobe.
- data_over  out  1  one-cycle pulse: sample consumed, advance address.
- BCLK  out  1  I2S bit clock.
- LRCLK  out  1  I2S word select; 0 = left, 1 = right.
- DACDAT  out  1  I2S serial data, MSB first.

Behaviour:
- Reset asserted (low): immediately, regardless of clock, BCLK=0, LRCLK=1, DACDAT=0, sample_req=0, data_over=0. State=IDLE, counters=0, buffer=0, frame register=0, stop flag=0.
- States: IDLE, FILL, RUN.
- IDLE: outputs held at reset values. INIT=1 -> FILL; sample_req=1 for the first FILL cycle.
- FILL: wait counter runs. Exactly ROM_LAT cycles after the sample_req cycle, buffer <= Sample and go to RUN with div_cnt=0, bit_cnt=2*SLOT_W-1, BCLK=0.
- RUN, divider: div_cnt counts 0..BCLK_DIV-1; at BCLK_DIV-1 it wraps and BCLK toggles.
- RUN, falling BCLK edges (BCLK 1->0): all BCLK-domain updates happen here.
  - bit_cnt <= (bit_cnt+1) mod 2*SLOT_W.
  - LRCLK <= 0 when new bit_cnt=0; LRCLK <= 1 when new bit_cnt=SLOT_W.
  - With k = new bit_cnt mod SLOT_W: DACDAT <= frame[DATA_W-k] for 1<=k<=DATA_W, else 0. This gives the one-BCLK I2S delay and zero-padded slot tail.
  - Same sample is sent on both channels.
- Frame boundary (falling edge with new bit_cnt=0):
  - frame <= buffer.
  - sample_req=1 and data_over=1 for exactly that one Clk cycle.
  - buffer <= Sample exactly ROM_LAT cycles later.
- Latency: first frame boundary occurs 2*BCLK_DIV Clk cycles after entering RUN. Frame period is 4*BCLK_DIV*SLOT_W Clk cycles (256 at BCLK_DIV=2, SLOT_W=32).
- Stop: INIT=0 while in RUN sets the stop flag. The current frame completes through its final falling edge. At the would-be frame boundary the block instead enters IDLE: BCLK=0, LRCLK=1, DACDAT=0, no sample_req, no data_over, stop flag cleared.
- INIT re-asserted before that boundary clears the stop flag; streaming continues uninterrupted.
- INIT=0 during FILL: complete the latch, then go to IDLE instead of RUN.
- A pending buffer latch is always completed before the next frame boundary; the ROM_LAT bound guarantees no underrun.
- Sample is sampled only on latch cycles; changes at other times have no effect.
- Reset mid-frame: immediate return to reset values; no partial frame resumes.

Optional Feature:
- Macro AUDIO_TX_ATTEN_EN.
- Defined: adds input port Atten [2:0]. On each buffer latch, buffer <= Sample >>> Atten (arithmetic shift, sign preserved). Atten is sampled on the latch cycle.
- Undefined: no Atten port; buffer <= Sample unmodified.

Test Plan:
- Reset with INIT=0 -> BCLK=0, LRCLK=1, DACDAT=0, sample_req=0, data_over=0; all remain static for 1000 cycles.
- Parameters DATA_W=16, SLOT_W=32, BCLK_DIV=2, ROM_LAT=2; INIT rises, Sample=16'hA5C3 -> one sample_req. First falling edge is 4 cycles after entering RUN: LRCLK=0. DACDAT slots 1..16 = 1010010111000011, slots 17..31 = 0; right channel identical with LRCLK=1.
- ROM model returns Address+1 after ROM_LAT with the generator advancing on data_over -> data_over pulses exactly every 256 Clk. Frame n carries the value fetched at boundary n-1; no duplicate or skipped samples.
- INIT dropped at bit_cnt=10 -> frame completes through bit_cnt=63, then IDLE outputs. No further sample_req or data_over.
- Reset asserted asynchronously mid-slot, between Clk edges -> outputs take reset values before the next Clk edge. After release with INIT=1, a normal FILL/RUN start follows.
- AUDIO_TX_ATTEN_EN defined, Atten=3, Sample=16'h8000 -> transmitted word 16'hF000; Atten=0 -> 16'h8000.
